// File: rtl/pcpu_pkg.sv
// Shared types for the pcpu accumulator core: opcodes, FSM states, ALU ops
// and instruction field-position helpers.
package pcpu_pkg;

    localparam int OP_W = 4;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_LDI  = 4'h1,
        OP_MOV  = 4'h2,
        OP_ADD  = 4'h3,
        OP_SUB  = 4'h4,
        OP_AND  = 4'h5,
        OP_OR   = 4'h6,
        OP_XOR  = 4'h7,
        OP_ADDI = 4'h8,
        OP_STA  = 4'h9,
        OP_JMP  = 4'hA,
        OP_JZ   = 4'hB,
        OP_JC   = 4'hC,
        OP_CALL = 4'hD,
        OP_RET  = 4'hE,
        OP_HLT  = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4
    } alu_op_e;

    // Instruction layout is {op, ra, opb}; opb occupies the low DATA_W bits.
    function automatic int instr_width(input int ra_w, input int data_w);
        return OP_W + ra_w + data_w;
    endfunction

    function automatic int ra_lsb(input int data_w);
        return data_w;
    endfunction

    function automatic int op_lsb(input int ra_w, input int data_w);
        return ra_w + data_w;
    endfunction

endpackage

// File: rtl/pcpu_alu.sv
// Combinational ALU for the pcpu core: add/sub with carry-borrow, bitwise ops,
// and a zero flag derived from the result.
module pcpu_alu
    import pcpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  alu_op_e           op_i,
    output logic [DATA_W-1:0] result_o,
    output logic              carry_o,
    output logic              zero_o
);

    logic [DATA_W:0] sum;

    always_comb begin
        sum      = {1'b0, a_i} + {1'b0, b_i};
        result_o = '0;
        carry_o  = 1'b0;
        case (op_i)
            ALU_ADD: begin
                result_o = sum[DATA_W-1:0];
                carry_o  = sum[DATA_W];
            end
            ALU_SUB: begin
                // Carry doubles as unsigned borrow on subtraction.
                result_o = a_i - b_i;
                carry_o  = (a_i < b_i);
            end
            ALU_AND: result_o = a_i & b_i;
            ALU_OR:  result_o = a_i | b_i;
            ALU_XOR: result_o = a_i ^ b_i;
            default: result_o = '0;
        endcase
    end

    assign zero_o = (result_o == '0);

endmodule

// File: rtl/pcpu_core.sv
// Multi-cycle accumulator core: FETCH/EXEC/HALT FSM, register file, Z/C flags.
// Define PCPU_CALL_EN to enable the single-entry CALL/RET link register.
module pcpu_core
    import pcpu_pkg::*;
#(
    parameter int  DATA_W  = 8,
    parameter int  REG_N   = 8,
    parameter int  PC_W    = 8,
    localparam int RA_W    = $clog2(REG_N),
    localparam int INSTR_W = 4 + RA_W + DATA_W
) (
    input  logic               clk,
    input  logic               reset,
    output logic [PC_W-1:0]    imem_addr,
    output logic               imem_req,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               imem_valid,
    output logic [DATA_W-1:0]  acc_out,
    output logic               flag_z,
    output logic               flag_c,
    output logic               halted,
    output logic               retire
);

    localparam int OP_LSB = op_lsb(RA_W, DATA_W);
    localparam int RA_LSB = ra_lsb(DATA_W);

    state_e              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [INSTR_W-1:0]  ir_q, ir_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic                z_q, z_d;
    logic                c_q, c_d;
    logic [DATA_W-1:0]   regs_q [REG_N];
`ifdef PCPU_CALL_EN
    logic [PC_W-1:0]     link_q, link_d;
`endif

    logic                rf_we;
    logic [DATA_W-1:0]   rf_wdata;

    opcode_e             op;
    logic [RA_W-1:0]     ra, rb;
    logic [DATA_W-1:0]   opb, ra_val, rb_val;
    logic [PC_W-1:0]     pc_inc, target;

    alu_op_e             alu_op;
    logic [DATA_W-1:0]   alu_b, alu_res;
    logic                alu_c, alu_z;

    assign op     = opcode_e'(ir_q[OP_LSB +: OP_W]);
    assign ra     = ir_q[RA_LSB +: RA_W];
    assign opb    = ir_q[DATA_W-1:0];
    assign rb     = opb[RA_W-1:0];
    assign target = opb[PC_W-1:0];
    assign ra_val = regs_q[ra];
    assign rb_val = regs_q[rb];
    assign pc_inc = pc_q + PC_W'(1);

    always_comb begin
        alu_op = ALU_ADD;
        alu_b  = rb_val;
        case (op)
            OP_SUB:  alu_op = ALU_SUB;
            OP_AND:  alu_op = ALU_AND;
            OP_OR:   alu_op = ALU_OR;
            OP_XOR:  alu_op = ALU_XOR;
            OP_ADDI: alu_b  = opb;
            default: alu_op = ALU_ADD;
        endcase
    end

    pcpu_alu #(.DATA_W(DATA_W)) u_alu (
        .a_i      (ra_val),
        .b_i      (alu_b),
        .op_i     (alu_op),
        .result_o (alu_res),
        .carry_o  (alu_c),
        .zero_o   (alu_z)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        acc_d    = acc_q;
        z_d      = z_q;
        c_d      = c_q;
        rf_we    = 1'b0;
        rf_wdata = opb;
`ifdef PCPU_CALL_EN
        link_d   = link_q;
`endif
        case (state_q)
            ST_FETCH: begin
                if (imem_valid) begin
                    ir_d    = imem_data;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                pc_d    = pc_inc;
                case (op)
                    OP_LDI: begin
                        rf_we    = 1'b1;
                        rf_wdata = opb;
                    end
                    OP_MOV: begin
                        rf_we    = 1'b1;
                        rf_wdata = rb_val;
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDI: begin
                        acc_d = alu_res;
                        z_d   = alu_z;
                        c_d   = alu_c;
                    end
                    OP_STA: begin
                        rf_we    = 1'b1;
                        rf_wdata = acc_q;
                    end
                    OP_JMP: pc_d = target;
                    OP_JZ:  if (z_q) pc_d = target;
                    OP_JC:  if (c_q) pc_d = target;
`ifdef PCPU_CALL_EN
                    OP_CALL: begin
                        link_d = pc_inc;
                        pc_d   = target;
                    end
                    OP_RET: pc_d = link_q;
`endif
                    OP_HLT: state_d = ST_HALT;
                    default: pc_d = pc_inc;
                endcase
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            acc_q   <= '0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
`ifdef PCPU_CALL_EN
            link_q  <= '0;
`endif
            for (int i = 0; i < REG_N; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            acc_q   <= acc_d;
            z_q     <= z_d;
            c_q     <= c_d;
`ifdef PCPU_CALL_EN
            link_q  <= link_d;
`endif
            if (rf_we) begin
                regs_q[ra] <= rf_wdata;
            end
        end
    end

    // Request and status are masked while reset is held so nothing leaks out
    // of a core caught mid-fetch or mid-execute.
    assign imem_req  = (state_q == ST_FETCH) && !reset;
    assign retire    = (state_q == ST_EXEC) && !reset;
    assign halted    = (state_q == ST_HALT) && !reset;
    assign imem_addr = pc_q;
    assign acc_out   = acc_q;
    assign flag_z    = z_q;
    assign flag_c    = c_q;

endmodule

// File: tb/tb_pcpu_core.sv
// Self-checking bench for pcpu_core: table-driven ALU vectors, hand-written
// corner sequences and random programs checked against an ISA-level model.
module tb_pcpu_core;

    localparam int DW = 8;
    localparam int PW = 8;
    localparam int IW = 15;

    logic          clk;
    logic          reset;
    logic [PW-1:0] imem_addr;
    logic          imem_req;
    logic [IW-1:0] imem_data;
    logic          imem_valid;
    logic [DW-1:0] acc_out;
    logic          flag_z;
    logic          flag_c;
    logic          halted;
    logic          retire;

    pcpu_core dut (
        .clk        (clk),
        .reset      (reset),
        .imem_addr  (imem_addr),
        .imem_req   (imem_req),
        .imem_data  (imem_data),
        .imem_valid (imem_valid),
        .acc_out    (acc_out),
        .flag_z     (flag_z),
        .flag_c     (flag_c),
        .halted     (halted),
        .retire     (retire)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- program memory responder ----------------
    logic [IW-1:0] mem [256];
    int  wait_n   = 0;
    int  wcnt     = 0;
    bit  stray_en = 1'b0;

    initial begin
        imem_valid = 1'b0;
        imem_data  = '0;
        forever begin
            @(negedge clk);
            if (imem_req) begin
                if (wcnt >= wait_n) begin
                    imem_valid = 1'b1;
                    imem_data  = mem[imem_addr];
                    wcnt       = 0;
                end else begin
                    imem_valid = 1'b0;
                    imem_data  = IW'($urandom);
                    wcnt++;
                end
            end else begin
                wcnt       = 0;
                imem_valid = stray_en;
                imem_data  = IW'($urandom);
            end
        end
    end

    function automatic logic [IW-1:0] ins(input logic [3:0] op, input logic [2:0] ra, input logic [7:0] opb);
        return {op, ra, opb};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = ins(4'hF, 3'd0, 8'd0);
    endtask

    // ---------------- ISA-level reference model ----------------
    int m_r [8];
    int m_acc, m_pc, m_link;
    bit m_z, m_c, m_halted;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_r[i] = 0;
        m_acc = 0; m_pc = 0; m_link = 0;
        m_z = 0; m_c = 0; m_halted = 0;
    endtask

    task automatic model_set_acc(input int res);
        m_acc = res % 256;
        m_z   = (m_acc == 0);
    endtask

    task automatic model_step();
        logic [IW-1:0] w;
        int op, ra, opb, rb, a, b, res, nxt;
        w   = mem[m_pc];
        op  = int'(w[14:11]);
        ra  = int'(w[10:8]);
        opb = int'(w[7:0]);
        rb  = opb % 8;
        a   = m_r[ra];
        b   = m_r[rb];
        nxt = (m_pc + 1) % 256;
        case (op)
            1:  m_r[ra] = opb;
            2:  m_r[ra] = b;
            3:  begin res = a + b;   m_c = (res > 255); model_set_acc(res); end
            4:  begin m_c = (a < b); model_set_acc(a - b + 256); end
            5:  begin m_c = 0; model_set_acc(a & b); end
            6:  begin m_c = 0; model_set_acc(a | b); end
            7:  begin m_c = 0; model_set_acc(a ^ b); end
            8:  begin res = a + opb; m_c = (res > 255); model_set_acc(res); end
            9:  m_r[ra] = m_acc;
            10: nxt = opb;
            11: if (m_z) nxt = opb;
            12: if (m_c) nxt = opb;
`ifdef PCPU_CALL_EN
            13: begin m_link = nxt; nxt = opb; end
            14: nxt = m_link;
`endif
            15: m_halted = 1;
            default: ;
        endcase
        m_pc = nxt;
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req",    32'(imem_req),  32'd0);
        chk("rst_addr",   32'(imem_addr), 32'd0);
        chk("rst_acc",    32'(acc_out),   32'd0);
        chk("rst_z",      32'(flag_z),    32'd0);
        chk("rst_c",      32'(flag_c),    32'd0);
        chk("rst_halted", 32'(halted),    32'd0);
        chk("rst_retire", 32'(retire),    32'd0);
        model_reset();
        reset = 1'b0;
    endtask

    // ---------------- scoreboard ----------------
    logic [PW-1:0] exp_q [$];
    logic [PW-1:0] fetch_log [$];
    int n_ret;
    int halt_cyc;

    // Runs until the model halts or max_ret instructions retire; every retire
    // is checked against the model's PC, and its results one cycle later.
    task automatic run_check(input int max_cyc, input int max_ret);
        bit            pend;
        bit            prev_stall;
        logic [PW-1:0] prev_addr;
        pend       = 0;
        prev_stall = 0;
        prev_addr  = '0;
        n_ret      = 0;
        halt_cyc   = -1;
        fetch_log.delete();
        for (int cyc = 1; cyc <= max_cyc; cyc++) begin
            @(negedge clk); #1;
            if (prev_stall) begin
                chk("stall_req",  32'(imem_req),  32'd1);
                chk("stall_addr", 32'(imem_addr), 32'(prev_addr));
            end
            if (pend) begin
                chk("acc", 32'(acc_out), 32'(m_acc));
                chk("z",   32'(flag_z),  32'(m_z));
                chk("c",   32'(flag_c),  32'(m_c));
                if (!m_halted) chk("next_addr", 32'(imem_addr), 32'(m_pc));
                pend = 0;
            end
            if (m_halted) begin
                halt_cyc = cyc - 1;
                chk("halted",      32'(halted),   32'd1);
                chk("halt_req",    32'(imem_req), 32'd0);
                repeat (3) @(negedge clk);
                #1;
                chk("halt_retire", 32'(retire),   32'd0);
                chk("halt_hold",   32'(halted),   32'd1);
                chk("halt_acc",    32'(acc_out),  32'(m_acc));
                return;
            end
            if (n_ret >= max_ret) return;
            if (retire) begin
                chk("exec_addr", 32'(imem_addr), 32'(m_pc));
                fetch_log.push_back(PW'(m_pc));
                model_step();
                n_ret++;
                pend = 1;
            end
            prev_stall = imem_req && !imem_valid;
            prev_addr  = imem_addr;
        end
        n_checks++;
        n_errors++;
        $display("FAIL run_timeout: no halt within %0d cycles, retired %0d", max_cyc, n_ret);
    endtask

    task automatic chk_log(input string name);
        chk({name, "_len"}, 32'(fetch_log.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < fetch_log.size(); i++)
            chk($sformatf("%s_%0d", name, i), 32'(fetch_log[i]), 32'(exp_q[i]));
        exp_q.delete();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_acc;
        logic       exp_z;
        logic       exp_c;
    } vec_t;

    vec_t vecs [11];

    initial begin
        reset = 1'b1;
        clear_mem();
        model_reset();

        vecs[0]  = '{4'h3, 8'd200, 8'd100, 8'd44,  1'b0, 1'b1};
        vecs[1]  = '{4'h3, 8'd0,   8'd0,   8'd0,   1'b1, 1'b0};
        vecs[2]  = '{4'h3, 8'd128, 8'd128, 8'd0,   1'b1, 1'b1};
        vecs[3]  = '{4'h4, 8'd5,   8'd5,   8'd0,   1'b1, 1'b0};
        vecs[4]  = '{4'h4, 8'd3,   8'd5,   8'd254, 1'b0, 1'b1};
        vecs[5]  = '{4'h4, 8'd9,   8'd4,   8'd5,   1'b0, 1'b0};
        vecs[6]  = '{4'h5, 8'hF0,  8'h3C,  8'h30,  1'b0, 1'b0};
        vecs[7]  = '{4'h6, 8'h00,  8'h00,  8'h00,  1'b1, 1'b0};
        vecs[8]  = '{4'h7, 8'hAA,  8'h55,  8'hFF,  1'b0, 1'b0};
        vecs[9]  = '{4'h7, 8'h5A,  8'h5A,  8'h00,  1'b1, 1'b0};
        vecs[10] = '{4'h8, 8'd250, 8'd6,   8'd0,   1'b1, 1'b1};

        // LDI R1,a; LDI R2,b; op; HLT -- 4 retires, halted after 8 cycles.
        for (int v = 0; v < 11; v++) begin
            clear_mem();
            mem[0] = ins(4'h1, 3'd1, vecs[v].a);
            mem[1] = ins(4'h1, 3'd2, vecs[v].b);
            mem[2] = (vecs[v].op == 4'h8) ? ins(4'h8, 3'd1, vecs[v].b) : ins(vecs[v].op, 3'd1, 8'd2);
            wait_n = 0;
            do_reset();
            run_check(200, 100);
            chk($sformatf("vec%0d_acc", v),  32'(acc_out), 32'(vecs[v].exp_acc));
            chk($sformatf("vec%0d_z", v),    32'(flag_z),  32'(vecs[v].exp_z));
            chk($sformatf("vec%0d_c", v),    32'(flag_c),  32'(vecs[v].exp_c));
            chk($sformatf("vec%0d_ret", v),  32'(n_ret),    32'd4);
            chk($sformatf("vec%0d_hcyc", v), 32'(halt_cyc), 32'd8);
        end

        // Three wait cycles per fetch: 5 cycles per instruction, same result.
        clear_mem();
        mem[0] = ins(4'h1, 3'd1, 8'd200);
        mem[1] = ins(4'h1, 3'd2, 8'd100);
        mem[2] = ins(4'h3, 3'd1, 8'd2);
        wait_n = 3;
        do_reset();
        run_check(400, 100);
        chk("wait3_hcyc", 32'(halt_cyc), 32'd20);
        chk("wait3_acc",  32'(acc_out),  32'd44);
        chk("wait3_c",    32'(flag_c),   32'd1);
        wait_n = 0;

        // SUB to zero then taken JZ.
        clear_mem();
        mem[0] = ins(4'h1, 3'd1, 8'd5);
        mem[1] = ins(4'h4, 3'd1, 8'd1);
        mem[2] = ins(4'hB, 3'd0, 8'h10);
        do_reset();
        run_check(200, 100);
        chk("subz_acc", 32'(acc_out), 32'd0);
        chk("subz_z",   32'(flag_z),  32'd1);
        chk("subz_c",   32'(flag_c),  32'd0);
        exp_q = '{8'h00, 8'h01, 8'h02, 8'h10};
        chk_log("jz_log");

        // PC wrap past 0xFF with stray valid pulses outside FETCH.
        clear_mem();
        mem[0]    = ins(4'hC, 3'd0, 8'h05);
        mem[1]    = ins(4'h1, 3'd1, 8'hFF);
        mem[2]    = ins(4'h8, 3'd1, 8'h01);
        mem[3]    = ins(4'hA, 3'd0, 8'hFE);
        mem[8'hFE] = ins(4'h0, 3'd0, 8'h00);
        mem[8'hFF] = ins(4'h0, 3'd0, 8'h00);
        stray_en = 1'b1;
        do_reset();
        run_check(200, 100);
        stray_en = 1'b0;
        exp_q = '{8'h00, 8'h01, 8'h02, 8'h03, 8'hFE, 8'hFF, 8'h00, 8'h05};
        chk_log("wrap_log");

        // CALL/RET.
        clear_mem();
        mem[0]     = ins(4'hA, 3'd0, 8'h03);
        mem[3]     = ins(4'hD, 3'd0, 8'h20);
        mem[8'h20] = ins(4'hE, 3'd0, 8'h00);
        do_reset();
        run_check(200, 100);
`ifdef PCPU_CALL_EN
        exp_q = '{8'h00, 8'h03, 8'h20, 8'h04};
`else
        exp_q = '{8'h00, 8'h03, 8'h04};
`endif
        chk_log("call_log");

        // Reset in the middle of a stalled fetch after registers were loaded.
        clear_mem();
        mem[0] = ins(4'h1, 3'd1, 8'd77);
        mem[1] = ins(4'h8, 3'd1, 8'd0);
        wait_n = 2;
        do_reset();
        run_check(200, 2);
        chk("pre_rst_acc", 32'(acc_out), 32'd77);
        @(posedge clk); #1;
        chk("stall_before_rst", 32'(imem_req), 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_mid_req", 32'(imem_req), 32'd0);
        mem[0] = ins(4'h3, 3'd1, 8'd2);
        mem[1] = ins(4'hF, 3'd0, 8'd0);
        do_reset();
        run_check(200, 100);
        chk("post_rst_acc", 32'(acc_out), 32'd0);
        chk("post_rst_z",   32'(flag_z),  32'd1);
        exp_q = '{8'h00, 8'h01};
        chk_log("post_rst_log");
        wait_n = 0;

        // Random programs against the reference model.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 256; i++) begin
                logic [3:0] op;
                op = 4'($urandom_range(0, 14));
                if ($urandom_range(0, 29) == 0) op = 4'hF;
                mem[i] = ins(op, 3'($urandom_range(0, 7)), 8'($urandom));
            end
            wait_n   = $urandom_range(0, 2);
            stray_en = (r % 2 == 1);
            do_reset();
            run_check(2000, 60);
        end
        stray_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
